// File: rtl/bist_seq_ctrl.sv
// BIST sequencer: runs n_pass+1 passes of INIT / RUNNING(run_len) / FINISH,
// with sticky completion and abort flags and a divided toggle during RUNNING.
module bist_seq_ctrl #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned PASS_W     = 2,
    parameter int unsigned TOGGLE_DIV = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  run_len,
    input  logic [PASS_W-1:0] n_pass,
    output logic              init,
    output logic              running,
    output logic              toggle,
    output logic              finish,
    output logic              bist_end,
    output logic              aborted,
    output logic              busy,
    output logic [PASS_W-1:0] pass_idx
);
    localparam int unsigned TDIV_W = 8;

    typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_RUN, ST_FIN} state_e;

    state_e            state_q, state_d;
    logic              start_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  last_cnt;
    logic [PASS_W-1:0] npass_q, npass_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic [TDIV_W-1:0] tdiv_q, tdiv_d;
    logic              tog_q, tog_d;
    logic              bist_end_q, bist_end_d;
    logic              aborted_q, aborted_d;
    logic              init_q, running_q, toggle_q, finish_q, busy_q;
    logic              start_acc;

    // Next-state, datapath and flag updates
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        npass_d    = npass_q;
        pass_d     = pass_q;
        tdiv_d     = tdiv_q;
        tog_d      = tog_q;
        bist_end_d = bist_end_q;
        aborted_d  = aborted_q;
        start_acc  = start & ~start_q & (state_q == ST_IDLE) & ~abort;
        // A zero run length still gives one RUNNING cycle
        last_cnt   = (len_q == '0) ? '0 : len_q - CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    len_d      = run_len;
                    npass_d    = n_pass;
                    pass_d     = '0;
                    cnt_d      = '0;
                    bist_end_d = 1'b0;
                    aborted_d  = 1'b0;
                    state_d    = ST_INIT;
                end
            end
            ST_INIT: begin
                cnt_d   = '0;
                tdiv_d  = '0;
                tog_d   = 1'b0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_q == last_cnt) begin
                    cnt_d   = '0;
                    state_d = ST_FIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (tdiv_q == TDIV_W'(TOGGLE_DIV - 1)) begin
                    tdiv_d = '0;
                    tog_d  = ~tog_q;
                end else begin
                    tdiv_d = tdiv_q + TDIV_W'(1);
                end
            end
            ST_FIN: begin
                if (pass_q < npass_q) begin
                    pass_d  = pass_q + PASS_W'(1);
                    state_d = ST_INIT;
                end else begin
                    bist_end_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over everything else, including completion in FINISH
        if (abort && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            pass_d     = pass_q;
            bist_end_d = bist_end_q;
            aborted_d  = 1'b1;
        end
    end

    // State, datapath and registered Moore outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b1;
            cnt_q      <= '0;
            len_q      <= '0;
            npass_q    <= '0;
            pass_q     <= '0;
            tdiv_q     <= '0;
            tog_q      <= 1'b0;
            bist_end_q <= 1'b0;
            aborted_q  <= 1'b0;
            init_q     <= 1'b0;
            running_q  <= 1'b0;
            toggle_q   <= 1'b0;
            finish_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            npass_q    <= npass_d;
            pass_q     <= pass_d;
            tdiv_q     <= tdiv_d;
            tog_q      <= tog_d;
            bist_end_q <= bist_end_d;
            aborted_q  <= aborted_d;
            init_q     <= (state_d == ST_INIT);
            running_q  <= (state_d == ST_RUN);
            toggle_q   <= (state_d == ST_RUN) & tog_d;
            finish_q   <= (state_d == ST_FIN);
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign init     = init_q;
    assign running  = running_q;
    assign toggle   = toggle_q;
    assign finish   = finish_q;
    assign bist_end = bist_end_q;
    assign aborted  = aborted_q;
    assign busy     = busy_q;
    assign pass_idx = pass_q;

endmodule
